instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// InstrMemLoader: run-time loadable instruction memory.
//
// Holds DEPTH instruction words. A program is streamed in through the load
// port while the CPU is stalled (oBusy), then the CPU fetches words with a
// single cycle of latency.
//
// Ports:
//   Clock        - sole clock, rising edge
//   Reset        - asynchronous, active-high reset
//   iAddress     - fetch address
//   iFetchEn     - fetch request
//   oInstruction - registered fetched word
//   oInstrValid  - oInstruction holds a valid fetched word
//   iLoadStart   - start a program load
//   iLoadCount   - number of words to load, sampled with iLoadStart
//   iLoadData    - load word
//   iLoadValid   - iLoadData is valid
//   oLoadReady   - a load word is accepted this cycle
//   oBusy        - load in progress, CPU must stall
//   oLoadDone    - one-cycle pulse when a load completes
//   oLoadError   - one-cycle pulse when a load request is rejected
module instr_mem_loader #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  input  logic                  iFetchEn,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstrValid,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadCount,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iLoadValid,
  output logic                  oLoadReady,
  output logic                  oBusy,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] One      = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptrNext;
  logic [ADDR_WIDTH-1:0] countReg;
  logic [ADDR_WIDTH-1:0] countNext;
  logic [ADDR_WIDTH-1:0] lastPtr;
  logic                  countOk;
  logic                  errorNext;
  logic                  writeEn;
  logic                  addrInRange;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A load request is only legal for a non-zero count that fits in memory.
  // The count is widened by one bit so DEPTH == 2^ADDR_WIDTH compares cleanly.
  assign countOk     = (iLoadCount != '0) && ({1'b0, iLoadCount} <= DepthExt);
  assign lastPtr     = countReg - One;
  assign addrInRange = ({1'b0, iAddress} < DepthExt);

  // Status outputs come straight from the state register so that an
  // asynchronous reset clears them immediately.
  assign oLoadReady = (state == LOAD);
  assign oBusy      = (state != IDLE);
  assign oLoadDone  = (state == DONE);

  // State, write pointer, latched count and the error pulse register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ptr        <= '0;
      countReg   <= '0;
      oLoadError <= 1'b0;
    end else begin
      state      <= stateNext;
      ptr        <= ptrNext;
      countReg   <= countNext;
      oLoadError <= errorNext;
    end
  end

  // Next-state logic. The pointer is cleared on the final accepted word
  // instead of incrementing, so it can never reach DEPTH even for a full
  // DEPTH-word load. iLoadStart is only looked at in IDLE.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    countNext = countReg;
    errorNext = 1'b0;
    writeEn   = 1'b0;
    case (state)
      IDLE: begin
        if (iLoadStart) begin
          if (countOk) begin
            countNext = iLoadCount;
            ptrNext   = '0;
            stateNext = LOAD;
          end else begin
            errorNext = 1'b1;
          end
        end
      end
      LOAD: begin
        if (iLoadValid) begin
          writeEn = 1'b1;
          if (ptr == lastPtr) begin
            ptrNext   = '0;
            stateNext = DONE;
          end else begin
            ptrNext = ptr + One;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Storage array. It is deliberately not reset so a program survives a
  // reset, including the words already written by an interrupted load.
  always_ff @(posedge Clock) begin
    if (writeEn) begin
      mem[ptr[IdxW-1:0]] <= iLoadData;
    end
  end

  // Registered fetch port. Fetches are only served in IDLE, so a read can
  // never collide with a load write; a blocked fetch returns DEFAULT_WORD
  // with valid low. Without a fetch request the word is held.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oInstruction <= DEFAULT_WORD;
      oInstrValid  <= 1'b0;
    end else if (iFetchEn) begin
      if (state == IDLE) begin
        oInstruction <= addrInRange ? mem[iAddress[IdxW-1:0]] : DEFAULT_WORD;
        oInstrValid  <= 1'b1;
      end else begin
        oInstruction <= DEFAULT_WORD;
        oInstrValid  <= 1'b0;
      end
    end else begin
      oInstrValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader with default parameters.
module tb_instr_mem_loader;

  localparam int DW    = 28;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam logic [DW-1:0] DEF = 28'h00000AA;

  typedef struct packed {
    logic [DW-1:0] word;
    logic          valid;
  } fetch_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          fetchEn;
  logic [DW-1:0] instruction;
  logic          instrValid;
  logic          loadStart;
  logic [AW-1:0] loadCount;
  logic [DW-1:0] loadData;
  logic          loadValid;
  logic          loadReady;
  logic          busy;
  logic          loadDone;
  logic          loadError;

  int compared   = 0;
  int mismatched = 0;

  fetch_t        expQ [$];
  logic [DW-1:0] model [DEPTH];

  instr_mem_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .DEFAULT_WORD(DEF)
  ) dut (
    .Clock       (clock),
    .Reset       (reset),
    .iAddress    (address),
    .iFetchEn    (fetchEn),
    .oInstruction(instruction),
    .oInstrValid (instrValid),
    .iLoadStart  (loadStart),
    .iLoadCount  (loadCount),
    .iLoadData   (loadData),
    .iLoadValid  (loadValid),
    .oLoadReady  (loadReady),
    .oBusy       (busy),
    .oLoadDone   (loadDone),
    .oLoadError  (loadError)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset values must appear without any clock edge.
  task automatic test_reset();
    fetch_t got;
    #1;
    compared++;
    if ({instruction, instrValid, loadReady, busy, loadDone, loadError} !== {DEF, 5'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %h/%b%b%b%b%b expected %h/00000",
               instruction, instrValid, loadReady, busy, loadDone, loadError, DEF);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || instrValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", busy, instrValid);
    end
    got = '0;
  endtask

  // Four-word load without bubbles, then read the words back.
  task automatic test_basic_load();
    logic [DW-1:0] w [4];
    fetch_t got;
    w[0] = 28'h1000007; w[1] = 28'h2000004; w[2] = 28'h3000082; w[3] = 28'h40002BC;
    loadStart = 1'b1; loadCount = 16'd4;
    tick();
    loadStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      loadData = w[i]; loadValid = 1'b1;
      compared++;
      if (loadReady !== 1'b1 || loadDone !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL basic_ready[%0d]: got ready=%b done=%b expected 1/0", i, loadReady, loadDone);
      end
      tick();
      model[i] = w[i];
    end
    loadValid = 1'b0;
    compared++;
    if ({loadDone, loadReady, busy} !== 3'b101) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got done/ready/busy=%b%b%b expected 101", loadDone, loadReady, busy);
    end
    tick();
    compared++;
    if ({loadDone, loadReady, busy} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL basic_idle: got done/ready/busy=%b%b%b expected 000", loadDone, loadReady, busy);
    end
    for (int i = 0; i < 4; i++) begin
      address = AW'(i); fetchEn = 1'b1;
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL basic_fetch[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
    expQ.push_back('{word: model[3], valid: 1'b0});
    tick();
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid} !== got) begin
      mismatched++;
      $display("[TB] FAIL fetch_hold: got %h/%b expected %h/%b", instruction, instrValid, got.word, got.valid);
    end
  endtask

  // Three-word load with bubbles; bubble cycles carry junk data.
  task automatic test_bubbled_load();
    logic [DW-1:0] bw [3];
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    fetch_t got;
    bw[0] = 28'h5000011; bw[1] = 28'h6000022; bw[2] = 28'h7000033;
    loadStart = 1'b1; loadCount = 16'd3;
    tick();
    loadStart = 1'b0;
    for (int c = 0; c < 6; c++) begin
      loadValid = (pat[c] != 0);
      loadData  = (pat[c] != 0) ? bw[k] : (28'hBAD0000 | DW'(c));
      compared++;
      if (loadReady !== 1'b1 || loadDone !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bubble_cycle[%0d]: got ready=%b done=%b expected 1/0", c, loadReady, loadDone);
      end
      tick();
      if (pat[c] != 0) begin
        model[k] = bw[k];
        k++;
      end
    end
    loadValid = 1'b0;
    compared++;
    if (loadDone !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bubble_done: got %b expected 1", loadDone);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      address = AW'(i); fetchEn = 1'b1;
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL bubble_fetch[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
  endtask

  // Zero and oversize counts are rejected with a single error pulse.
  task automatic test_rejected();
    logic [AW-1:0] bad [2];
    fetch_t got;
    bad[0] = 16'd0; bad[1] = AW'(DEPTH + 1);
    for (int r = 0; r < 2; r++) begin
      loadStart = 1'b1; loadCount = bad[r]; loadValid = 1'b1; loadData = 28'hEEEEEEE;
      tick();
      loadStart = 1'b0; loadValid = 1'b0;
      compared++;
      if ({loadError, busy} !== 2'b10) begin
        mismatched++;
        $display("[TB] FAIL reject_pulse[%0d]: got error/busy=%b%b expected 10", r, loadError, busy);
      end
      tick();
      compared++;
      if ({loadError, busy} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL reject_end[%0d]: got error/busy=%b%b expected 00", r, loadError, busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      address = AW'(i); fetchEn = 1'b1;
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL reject_mem[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
  endtask

  // Out-of-range fetch, fetch alongside a load start, and fetches
  // blocked during LOAD and DONE.
  task automatic test_range_blocking();
    fetch_t got;
    address = AW'(DEPTH); fetchEn = 1'b1;
    expQ.push_back('{word: DEF, valid: 1'b1});
    tick();
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid} !== got) begin
      mismatched++;
      $display("[TB] FAIL range_fetch: got %h/%b expected %h/%b", instruction, instrValid, got.word, got.valid);
    end
    address = 16'd1; loadStart = 1'b1; loadCount = 16'd2;
    expQ.push_back('{word: model[1], valid: 1'b1});
    tick();
    loadStart = 1'b0;
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid, busy} !== {got, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL start_with_fetch: got %h/%b busy=%b expected %h/%b busy=1",
               instruction, instrValid, busy, got.word, got.valid);
    end
    address = 16'd0; loadValid = 1'b0;
    expQ.push_back('{word: DEF, valid: 1'b0});
    tick();
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid} !== got) begin
      mismatched++;
      $display("[TB] FAIL load_blocked: got %h/%b expected %h/%b", instruction, instrValid, got.word, got.valid);
    end
    fetchEn = 1'b0;
    loadValid = 1'b1; loadData = 28'hA0000A1;
    tick();
    model[0] = 28'hA0000A1;
    loadData = 28'hA0000A2;
    tick();
    model[1] = 28'hA0000A2;
    loadValid = 1'b0; fetchEn = 1'b1; address = 16'd0;
    expQ.push_back('{word: DEF, valid: 1'b0});
    tick();
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid} !== got) begin
      mismatched++;
      $display("[TB] FAIL done_blocked: got %h/%b expected %h/%b", instruction, instrValid, got.word, got.valid);
    end
    for (int i = 0; i < 2; i++) begin
      address = AW'(i);
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL range_reload[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
  endtask

  // Reset after two of five words; written words stay, the rest keep old data.
  task automatic test_reset_midload();
    fetch_t got;
    address = 16'd3; fetchEn = 1'b1;
    expQ.push_back('{word: model[3], valid: 1'b1});
    tick();
    got = expQ.pop_front();
    compared++;
    if ({instruction, instrValid} !== got) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_fetch: got %h/%b expected %h/%b", instruction, instrValid, got.word, got.valid);
    end
    fetchEn = 1'b0; loadStart = 1'b1; loadCount = 16'd5;
    tick();
    loadStart = 1'b0;
    loadValid = 1'b1; loadData = 28'hC000001;
    tick();
    model[0] = 28'hC000001;
    loadData = 28'hC000002;
    tick();
    model[1] = 28'hC000002;
    loadValid = 1'b0;
    compared++;
    if ({busy, loadReady} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL midload_busy: got busy/ready=%b%b expected 11", busy, loadReady);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({instruction, instrValid, loadReady, busy, loadDone, loadError} !== {DEF, 5'b0}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %h/%b%b%b%b%b expected %h/00000",
               instruction, instrValid, loadReady, busy, loadDone, loadError, DEF);
    end
    #2;
    reset = 1'b0;
    fetchEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = AW'(i);
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL reset_retain[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
  endtask

  // A second iLoadStart inside LOAD must not restart or shorten the load.
  task automatic test_ignored_restart();
    logic [DW-1:0] rw [3];
    fetch_t got;
    rw[0] = 28'hD000101; rw[1] = 28'hD000202; rw[2] = 28'hD000303;
    loadStart = 1'b1; loadCount = 16'd3;
    tick();
    loadStart = 1'b1; loadCount = 16'd1;
    loadValid = 1'b1; loadData = rw[0];
    tick();
    model[0] = rw[0];
    loadStart = 1'b0;
    loadData = rw[1];
    tick();
    model[1] = rw[1];
    compared++;
    if ({loadDone, busy} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL restart_not_done: got done/busy=%b%b expected 01", loadDone, busy);
    end
    loadData = rw[2];
    tick();
    model[2] = rw[2];
    loadValid = 1'b0;
    compared++;
    if (loadDone !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL restart_done: got %b expected 1", loadDone);
    end
    tick();
    fetchEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = AW'(i);
      expQ.push_back('{word: model[i], valid: 1'b1});
      tick();
      got = expQ.pop_front();
      compared++;
      if ({instruction, instrValid} !== got) begin
        mismatched++;
        $display("[TB] FAIL restart_fetch[%0d]: got %h/%b expected %h/%b", i, instruction, instrValid, got.word, got.valid);
      end
    end
    fetchEn = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    reset     = 1'b1;
    address   = '0;
    fetchEn   = 1'b0;
    loadStart = 1'b0;
    loadCount = '0;
    loadData  = '0;
    loadValid = 1'b0;
    test_reset();
    test_basic_load();
    test_bubbled_load();
    test_rejected();
    test_range_blocking();
    test_reset_midload();
    test_ignored_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
